// File: rtl/regfile_shadow.sv
// Double-buffered configuration register file: host writes go to a shadow bank,
// and an armed commit copies the dirty shadow registers into the active bank on a period boundary.
module regfile_shadow #(
  parameter int unsigned DATA_BITS = 16,
  parameter int unsigned NUM_REGS  = 6,
  parameter int unsigned ADDR_BITS = 3,
  parameter logic [NUM_REGS*DATA_BITS-1:0] RESET_VAL = {NUM_REGS*DATA_BITS{1'b0}}
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [ADDR_BITS-1:0]          wr_addr,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          rd_en,
  input  logic [ADDR_BITS-1:0]          rd_addr,
  input  logic                          rd_shadow,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic                          rd_err,
  output logic                          wr_err,
  input  logic                          commit_req,
  output logic                          commit_done,
  output logic                          armed,
  output logic                          pending,
  output logic [NUM_REGS*DATA_BITS-1:0] active_flat
);

  typedef enum logic {IDLE, ARMED} state_e;

  localparam logic [ADDR_BITS-1:0] CTRL_ADDR = ADDR_BITS'(NUM_REGS);

  state_e                 state_q, state_d;
  logic [DATA_BITS-1:0]   shadow_q [NUM_REGS];
  logic [DATA_BITS-1:0]   shadow_d [NUM_REGS];
  logic [DATA_BITS-1:0]   active_q [NUM_REGS];
  logic [DATA_BITS-1:0]   active_d [NUM_REGS];
  logic [NUM_REGS-1:0]    dirty_q, dirty_d;
  logic [DATA_BITS-1:0]   rd_data_q, rd_data_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   rd_err_q, rd_err_d;
  logic                   wr_err_q, wr_err_d;
  logic                   commit_done_q, commit_done_d;
  logic                   commit;

  assign armed   = (state_q == ARMED);
  assign pending = |dirty_q;
  assign commit  = commit_req && (state_q == ARMED);

  // Write path: the commit is evaluated on the current state first, then the
  // host write (data or CTRL) is layered on top of the post-commit values.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    state_d       = state_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    dirty_d       = dirty_q;
    wr_err_d      = 1'b0;
    commit_done_d = 1'b0;

    if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (dirty_q[i]) active_d[i] = shadow_q[i];
      end
      dirty_d       = '0;
      state_d       = IDLE;
      commit_done_d = 1'b1;
    end

    if (wr_en) begin
      if (wr_addr < CTRL_ADDR) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (wr_addr == ADDR_BITS'(i)) begin
            shadow_d[i] = wr_data;
            dirty_d[i]  = 1'b1;
          end
        end
      end else if (wr_addr == CTRL_ADDR) begin
        if (wr_data[1]) begin
          shadow_d = active_d;
          dirty_d  = '0;
          state_d  = IDLE;
        end else if (wr_data[0]) begin
          state_d = ARMED;
        end
      end else begin
        wr_err_d = 1'b1;
      end
    end
  end

  // Read path sees the pre-edge banks, so a same-cycle write is not visible yet.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_en;
    rd_err_d   = 1'b0;
    if (rd_en) begin
      rd_data_d = '0;
      if (rd_addr < CTRL_ADDR) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (rd_addr == ADDR_BITS'(i)) rd_data_d = rd_shadow ? shadow_q[i] : active_q[i];
        end
      end else if (rd_addr == CTRL_ADDR) begin
        rd_data_d[1:0] = {pending, armed};
      end else begin
        rd_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: both banks are reset explicitly because RESET_VAL is the defined power-up parameter set, not don't-care storage.
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= RESET_VAL[i*DATA_BITS +: DATA_BITS];
        active_q[i] <= RESET_VAL[i*DATA_BITS +: DATA_BITS];
      end
      state_q       <= IDLE;
      dirty_q       <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      rd_err_q      <= 1'b0;
      wr_err_q      <= 1'b0;
      commit_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value regardless of statement order.
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      state_q       <= state_d;
      dirty_q       <= dirty_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      rd_err_q      <= rd_err_d;
      wr_err_q      <= wr_err_d;
      commit_done_q <= commit_done_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign rd_err      = rd_err_q;
  assign wr_err      = wr_err_q;
  assign commit_done = commit_done_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign active_flat[g*DATA_BITS +: DATA_BITS] = active_q[g];
  end

endmodule

// File: tb/tb_regfile_shadow.sv
// Directed self-checking bench for regfile_shadow: double buffering, commit,
// arm/abort interaction, invalid accesses and reset.
module tb_regfile_shadow;

  localparam int DW = 16;
  localparam int NR = 6;
  localparam int AW = 3;
  localparam logic [NR*DW-1:0] RST_IMG = 96'h0000_0000_0000_0100_0000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_shadow;
  logic [DW-1:0] rd_data;
  logic          rd_valid, rd_err, wr_err;
  logic          commit_req, commit_done, armed, pending;
  logic [NR*DW-1:0] active_flat;

  logic [NR*DW-1:0] exp_active;
  int n_tests = 0;
  int n_fail  = 0;

  regfile_shadow #(
    .DATA_BITS(DW), .NUM_REGS(NR), .ADDR_BITS(AW), .RESET_VAL(RST_IMG)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_shadow(rd_shadow),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err), .wr_err(wr_err),
    .commit_req(commit_req), .commit_done(commit_done),
    .armed(armed), .pending(pending), .active_flat(active_flat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [NR*DW-1:0] got, input logic [NR*DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic idle_in();
    wr_en = 1'b0; rd_en = 1'b0; commit_req = 1'b0; rst = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    set_wr(a, d);
    tick();
    idle_in();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic sh);
    rd_en = 1'b1; rd_addr = a; rd_shadow = sh;
    tick();
    idle_in();
  endtask

  task automatic do_commit();
    commit_req = 1'b1;
    tick();
    idle_in();
  endtask

  function automatic logic [NR*DW-1:0] put(input logic [NR*DW-1:0] f, input int idx, input logic [DW-1:0] v);
    logic [NR*DW-1:0] r;
    r = f;
    r[idx*DW +: DW] = v;
    return r;
  endfunction

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; rd_shadow = 1'b0; commit_req = 1'b0;
    exp_active = RST_IMG;
    tick(); tick();
    idle_in();

    // 1: reset image
    check("rst_active", active_flat, exp_active);
    check("rst_armed", armed, 1'b0);
    check("rst_pending", pending, 1'b0);
    check("rst_valid", rd_valid, 1'b0);
    check("rst_cdone", commit_done, 1'b0);
    do_read(3'd2, 1'b1);
    check("rst_shadow2", rd_data, 16'h0100);
    check("rst_shadow2_valid", rd_valid, 1'b1);
    check("rst_shadow2_err", rd_err, 1'b0);
    tick();
    check("rd_valid_pulse", rd_valid, 1'b0);
    check("rd_data_hold", rd_data, 16'h0100);

    // 2: write goes to shadow only; commit while idle is ignored
    do_write(3'd1, 16'h1234);
    check("t2_pending", pending, 1'b1);
    do_read(3'd1, 1'b0);
    check("t2_active1", rd_data, 16'h0000);
    do_read(3'd1, 1'b1);
    check("t2_shadow1", rd_data, 16'h1234);
    do_read(3'd6, 1'b0);
    check("t2_ctrl_rd", rd_data, 16'h0002);
    do_commit();
    check("t2_idle_cdone", commit_done, 1'b0);
    check("t2_idle_active", active_flat, exp_active);

    // 3: arm + commit copies every dirty register (reg0 and the earlier reg1)
    do_write(3'd0, 16'hAAAA);
    do_write(3'd6, 16'h0001);
    check("t3_armed", armed, 1'b1);
    do_read(3'd6, 1'b0);
    check("t3_ctrl_rd", rd_data, 16'h0003);
    do_commit();
    exp_active = put(exp_active, 0, 16'hAAAA);
    exp_active = put(exp_active, 1, 16'h1234);
    check("t3_cdone", commit_done, 1'b1);
    check("t3_active", active_flat, exp_active);
    check("t3_armed_clr", armed, 1'b0);
    check("t3_pending_clr", pending, 1'b0);
    tick();
    check("t3_cdone_pulse", commit_done, 1'b0);
    // empty commit still completes
    do_write(3'd6, 16'h0001);
    do_commit();
    check("empty_cdone", commit_done, 1'b1);
    check("empty_active", active_flat, exp_active);

    // 4: write and commit in the same cycle
    do_write(3'd6, 16'h0001);
    set_wr(3'd3, 16'h5555);
    commit_req = 1'b1;
    tick();
    idle_in();
    check("t4_cdone", commit_done, 1'b1);
    check("t4_active", active_flat, exp_active);
    check("t4_pending", pending, 1'b1);
    check("t4_armed", armed, 1'b0);
    do_read(3'd3, 1'b1);
    check("t4_shadow3", rd_data, 16'h5555);
    // commit + ARM in the same cycle: commit happens, stays armed
    do_write(3'd6, 16'h0001);
    set_wr(3'd6, 16'h0001);
    commit_req = 1'b1;
    tick();
    idle_in();
    exp_active = put(exp_active, 3, 16'h5555);
    check("commit_arm_active", active_flat, exp_active);
    check("commit_arm_armed", armed, 1'b1);
    check("commit_arm_cdone", commit_done, 1'b1);

    // 5: abort restores shadow from active
    do_write(3'd4, 16'h0F0F);
    do_write(3'd6, 16'h0002);
    check("t5_pending", pending, 1'b0);
    check("t5_armed", armed, 1'b0);
    do_read(3'd4, 1'b1);
    check("t5_shadow4", rd_data, 16'h0000);
    do_commit();
    check("t5_cdone", commit_done, 1'b0);
    check("t5_active", active_flat, exp_active);
    // commit + ABORT in the same cycle
    do_write(3'd5, 16'h7777);
    do_write(3'd6, 16'h0001);
    set_wr(3'd6, 16'h0002);
    commit_req = 1'b1;
    tick();
    idle_in();
    exp_active = put(exp_active, 5, 16'h7777);
    check("commit_abort_active", active_flat, exp_active);
    check("commit_abort_armed", armed, 1'b0);
    check("commit_abort_cdone", commit_done, 1'b1);
    do_read(3'd5, 1'b1);
    check("commit_abort_shadow5", rd_data, 16'h7777);
    // ABORT has priority over ARM in the same CTRL write
    do_write(3'd0, 16'h1111);
    do_write(3'd6, 16'h0001);
    do_write(3'd6, 16'h0003);
    check("abort_prio_armed", armed, 1'b0);
    check("abort_prio_pending", pending, 1'b0);
    do_read(3'd0, 1'b1);
    check("abort_prio_shadow0", rd_data, 16'hAAAA);

    // 6: invalid accesses
    do_write(3'd7, 16'hFFFF);
    check("t6_wr_err", wr_err, 1'b1);
    check("t6_wr_err_active", active_flat, exp_active);
    check("t6_wr_err_pending", pending, 1'b0);
    tick();
    check("t6_wr_err_pulse", wr_err, 1'b0);
    do_read(3'd7, 1'b0);
    check("t6_rd_valid", rd_valid, 1'b1);
    check("t6_rd_err", rd_err, 1'b1);
    check("t6_rd_data", rd_data, 16'h0000);
    tick();
    check("t6_rd_err_pulse", rd_err, 1'b0);
    // read and write to the same address in one cycle returns the old value
    set_wr(3'd2, 16'hBEEF);
    rd_en = 1'b1; rd_addr = 3'd2; rd_shadow = 1'b1;
    tick();
    idle_in();
    check("rw_same_addr", rd_data, 16'h0100);
    // reset while armed with dirty registers and a commit request
    do_write(3'd1, 16'h9999);
    do_write(3'd6, 16'h0001);
    rst = 1'b1; commit_req = 1'b1;
    tick();
    idle_in();
    exp_active = RST_IMG;
    check("t6_rst_active", active_flat, exp_active);
    check("t6_rst_armed", armed, 1'b0);
    check("t6_rst_pending", pending, 1'b0);
    check("t6_rst_cdone", commit_done, 1'b0);
    do_read(3'd1, 1'b1);
    check("t6_rst_shadow1", rd_data, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
